// File: rtl/au_issue_stage.sv
// -----------------------------------------------------------------------------
// au_issue_stage
//   Flow-controlled front-end for the combinational arithmetic unit.
//   Requests are queued in a DEPTH-entry FIFO. The head entry drives the
//   arithmetic unit, and its result is captured in a valid/ready response
//   register. Divide-by-zero and signed-overflow division results are
//   replaced with defined values.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake; req_a, req_b, req_op, req_typ
//   au_ip_o           packed {a, b, op, typ} to the arithmetic unit (0 when empty)
//   au_res_i          combinational result from the arithmetic unit
//   rsp_valid/ready   response handshake; rsp_data, rsp_dz, rsp_op
//   occupancy         number of queued requests
// -----------------------------------------------------------------------------
module au_issue_stage #(
    parameter int DEPTH = 4,
    parameter int O_S   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [O_S-1:0]             req_a,
    input  logic [O_S-1:0]             req_b,
    input  logic [1:0]                 req_op,
    input  logic                       req_typ,
    output logic [2*O_S+2:0]           au_ip_o,
    input  logic [O_S-1:0]             au_res_i,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [O_S-1:0]             rsp_data,
    output logic                       rsp_dz,
    output logic [1:0]                 rsp_op,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2*O_S + 3;

    localparam logic [AW:0]    L_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]    L_OCC_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]  L_PTR_ONE = AW'(1);
    localparam logic [O_S-1:0] L_MIN_NEG = {1'b1, {(O_S-1){1'b0}}};
    localparam logic [O_S-1:0] L_MAX_POS = {1'b0, {(O_S-1){1'b1}}};

    // FIFO storage and pointers
    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_occ;

    // Response register
    logic           r_rsp_valid;
    logic [O_S-1:0] r_rsp_data;
    logic           r_rsp_dz;
    logic [1:0]     r_rsp_op;

    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic [EW-1:0]  w_head;
    logic [O_S-1:0] w_a;
    logic [O_S-1:0] w_b;
    logic [1:0]     w_op;
    logic           w_typ;
    logic           w_div;
    logic           w_bzero;
    logic           w_ovf;
    logic [O_S-1:0] w_res;
    logic           w_dz;

    // Ready depends only on registered occupancy: a pop in the same cycle
    // does not open a slot while full.
    assign req_ready = (r_occ != L_FULL);
    assign w_empty   = (r_occ == '0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = !w_empty && (!r_rsp_valid || rsp_ready);

    assign w_head    = r_mem[r_rd_ptr];
    assign au_ip_o   = w_empty ? '0 : w_head;

    assign w_a       = w_head[EW-1 -: O_S];
    assign w_b       = w_head[O_S+2 -: O_S];
    assign w_op      = w_head[2:1];
    assign w_typ     = w_head[0];

    assign w_div     = (w_op == 2'd3);
    assign w_bzero   = (w_b == '0);
    assign w_ovf     = w_div && w_typ && (w_a == L_MIN_NEG) && (w_b == '1);

    // Division corner cases replace whatever the arithmetic unit returns.
    always_comb begin
        w_res = au_res_i;
        w_dz  = 1'b0;
        if (w_div && w_bzero) begin
            w_dz = 1'b1;
            if (!w_typ)
                w_res = '1;
            else if (w_a[O_S-1])
                w_res = L_MIN_NEG;
            else
                w_res = L_MAX_POS;
        end else if (w_ovf) begin
            w_res = L_MIN_NEG;
        end
    end

    // Storage is not reset; pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {req_a, req_b, req_op, req_typ};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + L_OCC_ONE;
                2'b01:   r_occ <= r_occ - L_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_dz    <= 1'b0;
            r_rsp_op    <= '0;
        end else if (w_pop) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_res;
            r_rsp_dz    <= w_dz;
            r_rsp_op    <= w_op;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_dz    = r_rsp_dz;
    assign rsp_op    = r_rsp_op;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_au_issue_stage.sv
module tb_au_issue_stage;

    localparam int DEPTH = 4;
    localparam int O_S   = 16;
    localparam int EW    = 2*O_S + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [O_S-1:0]   req_a;
    logic [O_S-1:0]   req_b;
    logic [1:0]       req_op;
    logic             req_typ;
    logic [EW-1:0]    au_ip_o;
    logic [O_S-1:0]   au_res_i;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [O_S-1:0]   rsp_data;
    logic             rsp_dz;
    logic [1:0]       rsp_op;
    logic [$clog2(DEPTH):0] occupancy;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    au_issue_stage #(.DEPTH(DEPTH), .O_S(O_S)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_typ(req_typ),
        .au_ip_o(au_ip_o), .au_res_i(au_res_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_dz(rsp_dz), .rsp_op(rsp_op),
        .occupancy(occupancy)
    );

    // Stand-in arithmetic unit. Undefined division cases return junk that
    // the stage must discard.
    logic [O_S-1:0] alu_a, alu_b;
    always_comb begin
        alu_a    = au_ip_o[EW-1 -: O_S];
        alu_b    = au_ip_o[O_S+2 -: O_S];
        au_res_i = '0;
        case (au_ip_o[2:1])
            2'd0: au_res_i = alu_a + alu_b;
            2'd1: au_res_i = alu_a - alu_b;
            2'd2: au_res_i = alu_a * alu_b;
            default: begin
                if (alu_b == '0)
                    au_res_i = 16'h5A5A;
                else if (au_ip_o[0] && alu_a == 16'h8000 && alu_b == 16'hFFFF)
                    au_res_i = 16'h1234;
                else if (au_ip_o[0])
                    au_res_i = $signed(alu_a) / $signed(alu_b);
                else
                    au_res_i = alu_a / alu_b;
            end
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from arithmetic rules on integers: {dz, data}
    function automatic logic [O_S:0] exp_res(input logic [O_S-1:0] a, input logic [O_S-1:0] b,
                                             input logic [1:0] op, input logic typ);
        longint sa, sb, r, mask;
        logic dz;
        mask = (longint'(1) << O_S) - 1;
        sa = typ ? longint'($signed(a)) : longint'(a);
        sb = typ ? longint'($signed(b)) : longint'(b);
        dz = 1'b0;
        case (op)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            2'd2: r = sa * sb;
            default: begin
                if (sb == 0) begin
                    dz = 1'b1;
                    if (!typ)        r = mask;
                    else if (sa < 0) r = -(longint'(1) << (O_S-1));
                    else             r = (longint'(1) << (O_S-1)) - 1;
                end else begin
                    r = sa / sb;   // MIN/-1 becomes +2^(O_S-1) which wraps to MIN
                end
            end
        endcase
        return {dz, O_S'(r & mask)};
    endfunction

    // Behavioural model: queue of pending requests plus held response.
    typedef struct {
        logic [O_S-1:0] a;
        logic [O_S-1:0] b;
        logic [1:0]     op;
        logic           typ;
    } req_s;

    req_s           m_q[$];
    bit             m_valid;
    logic [O_S-1:0] m_data;
    logic           m_dz;
    logic [1:0]     m_op;

    always @(posedge clk) begin
        bit   push, pop;
        req_s h, n;
        logic [O_S:0] r;
        if (rst) begin
            m_q.delete();
            m_valid = 0; m_data = '0; m_dz = 0; m_op = '0;
        end else begin
            push = req_valid && (m_q.size() < DEPTH);
            pop  = (m_q.size() > 0) && (!m_valid || rsp_ready);
            if (pop) begin
                h = m_q.pop_front();
                r = exp_res(h.a, h.b, h.op, h.typ);
                m_valid = 1; m_data = r[O_S-1:0]; m_dz = r[O_S]; m_op = h.op;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
            if (push) begin
                n.a = req_a; n.b = req_b; n.op = req_op; n.typ = req_typ;
                m_q.push_back(n);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("occupancy", occupancy, m_q.size());
            chk("req_ready", req_ready, m_q.size() < DEPTH);
            chk("rsp_valid", rsp_valid, m_valid);
            if (m_valid) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_dz", rsp_dz, m_dz);
                chk("rsp_op", rsp_op, m_op);
            end
            if (m_q.size() > 0)
                chk("au_ip_o", au_ip_o, {m_q[0].a, m_q[0].b, m_q[0].op, m_q[0].typ});
            else
                chk("au_ip_o_idle", au_ip_o, '0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [O_S-1:0] a, input logic [O_S-1:0] b,
                           input logic [1:0] op, input logic typ);
        req_valid = v; req_a = a; req_b = b; req_op = op; req_typ = typ;
    endtask

    // One request into an idle stage; checks latency and literal result.
    task automatic do_one(input string name, input logic [O_S-1:0] a, input logic [O_S-1:0] b,
                          input logic [1:0] op, input logic typ,
                          input logic [O_S-1:0] ed, input logic edz);
        rsp_ready = 1;
        set_req(1, a, b, op, typ);
        cyc();                       // accept edge
        req_valid = 0;
        @(negedge clk);
        chk({name, "_lat1"}, rsp_valid, 0);
        cyc();                       // capture edge
        @(negedge clk);
        chk({name, "_valid"}, rsp_valid, 1);
        chk({name, "_data"}, rsp_data, ed);
        chk({name, "_dz"}, rsp_dz, edz);
        chk({name, "_op"}, rsp_op, op);
        cyc();
    endtask

    initial begin
        logic [O_S:0] pin;
        bit ok;
        rst = 1; rsp_ready = 0;
        set_req(0, '0, '0, '0, 0);
        cyc();
        chk_en = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_data", rsp_data, 0);

        // Pin the model against hand values
        pin = exp_res(16'h8000, 16'hFFFF, 2'd3, 1);
        chk("model_ovf", pin, 17'h08000);
        pin = exp_res(16'h0010, 16'h0000, 2'd3, 1);
        chk("model_dzpos", pin, 17'h17FFF);
        cyc();

        do_one("add",    16'h0005, 16'h0003, 2'd0, 0, 16'h0008, 0);
        do_one("smul",   16'hFFFE, 16'h0003, 2'd2, 1, 16'hFFFA, 0);
        do_one("usub",   16'h0001, 16'h0002, 2'd1, 0, 16'hFFFF, 0);
        do_one("udz",    16'h0010, 16'h0000, 2'd3, 0, 16'hFFFF, 1);
        do_one("sdzneg", 16'hFFF0, 16'h0000, 2'd3, 1, 16'h8000, 1);
        do_one("sdzpos", 16'h0010, 16'h0000, 2'd3, 1, 16'h7FFF, 1);
        do_one("sovf",   16'h8000, 16'hFFFF, 2'd3, 1, 16'h8000, 0);
        do_one("sdiv",   16'hFFF9, 16'h0002, 2'd3, 1, 16'hFFFD, 0);

        // Backpressure: 6 offered, 5 accepted
        rsp_ready = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1, 16'(i), 16'h0100, 2'd0, 0);
            cyc();
        end
        req_valid = 0;
        @(negedge clk);
        chk("bp_occ", occupancy, 4);
        chk("bp_ready", req_ready, 0);
        chk("bp_valid", rsp_valid, 1);
        cyc();
        rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", rsp_valid, 1);
            chk("bp_drain_data", rsp_data, 16'h0100 + 16'(i));
            cyc();
        end
        @(negedge clk);
        chk("bp_drained", rsp_valid, 0);
        cyc();

        // Stream of 16 with rsp_ready high: occupancy never above 1
        ok = 1;
        for (int i = 0; i < 16; i++) begin
            set_req(1, 16'(i * 3), 16'(i), 2'd1, 0);
            @(negedge clk);
            if (occupancy > 1) ok = 0;
            cyc();
        end
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (occupancy > 1) ok = 0;
            cyc();
        end
        chk("stream_occ_le1", ok, 1);

        // Reset with 3 queued and 1 held
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 16'h0AA0 + 16'(i), 16'h0001, 2'd0, 0);
            cyc();
        end
        req_valid = 0;
        @(negedge clk);
        chk("pre_rst_occ", occupancy, 3);
        chk("pre_rst_valid", rsp_valid, 1);
        rst = 1;
        cyc();
        rst = 0;
        rsp_ready = 1;
        @(negedge clk);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_ready", req_ready, 1);
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            if (rsp_valid !== 1'b0) ok = 0;
        end
        chk("no_stale_rsp", ok, 1);
        cyc();

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            logic [O_S-1:0] a, b;
            logic [1:0] op;
            int sel;
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; op = 2'd3; end
            set_req(1'($urandom_range(0, 3) != 0), a, b, op, 1'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 0;
        req_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < 8; i++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
